// File: rtl/rptr_empty_pkg.sv
// Shared asynchronous-FIFO helpers: Gray/binary conversion and pointer width.
package rptr_empty_pkg;

    localparam int unsigned FIFO_ASIZE = 4;
    localparam int unsigned FIFO_PTR_W = FIFO_ASIZE + 1;

    function automatic int unsigned ptr_width(input int unsigned asize);
        return asize + 1;
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR from the MSB; upper bits of a narrower pointer are zero.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = '0;
        for (int i = 0; i < 32; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/rptr_empty_sync_2ff.sv
// Two-flop synchroniser for a Gray-coded pointer crossing into this clock domain.
module sync_2ff #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] d_p0;
    logic [WIDTH-1:0] d_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            d_p0 <= '0;
            d_p1 <= '0;
        end else begin
            d_p0 <= d;
            d_p1 <= d_p0;
        end
    end

    assign q = d_p1;

endmodule

// File: rtl/rptr_empty.sv
// Read-side pointer and empty/almost-empty/level controller of the async FIFO.
module rptr_empty
    import rptr_empty_pkg::*;
#(
    parameter int DSIZE    = 8,
    parameter int ASIZE    = 4,
    parameter int AE_LEVEL = 1
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic             ren,
    input  logic [ASIZE:0]   wptr,
    output logic [ASIZE:0]   rptr,
    output logic [ASIZE-1:0] raddr,
    output logic             empty,
    output logic             almost_empty,
    output logic [ASIZE:0]   rlevel
);

    localparam int PW = ptr_width(ASIZE);

    if (DSIZE < 1 || AE_LEVEL < 0 || AE_LEVEL > (1 << ASIZE)) begin : g_bad_param
        $error("rptr_empty: DSIZE must be positive and AE_LEVEL within 0..2^ASIZE");
    end

    logic [PW-1:0] wptr_db;
    logic [PW-1:0] wbin_db;
    logic [PW-1:0] rbin;
    logic [PW-1:0] rgray;
    logic [PW-1:0] rbin_next;
    logic [PW-1:0] rgray_next;
    logic [PW-1:0] lvl_next;
    logic          rinc;

    sync_2ff #(.WIDTH(PW)) u_wptr_sync (
        .clk (rclk),
        .rst (rrst),
        .d   (wptr),
        .q   (wptr_db)
    );

    // Next-state pointers and level share one computation so a read and a
    // newly synchronised write in the same cycle combine correctly.
    always_comb begin
        rinc       = ren & ~empty;
        rbin_next  = rbin + PW'(rinc);
        rgray_next = PW'(bin2gray(32'(rbin_next)));
        wbin_db    = PW'(gray2bin(32'(wptr_db)));
        lvl_next   = wbin_db - rbin_next;
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            rbin         <= '0;
            rgray        <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            rlevel       <= '0;
        end else begin
            rbin         <= rbin_next;
            rgray        <= rgray_next;
            empty        <= (rgray_next == wptr_db);
            almost_empty <= (lvl_next <= PW'(AE_LEVEL));
            rlevel       <= lvl_next;
        end
    end

    assign rptr  = rgray;
    assign raddr = rbin[ASIZE-1:0];

endmodule
